// File: rtl/maze_move_checker.sv
// Path scoreboard for the maze solver: replays the 2-bit move stream over a
// local wall map and flags collisions, overrun past the goal and early Done.
module maze_move_checker #(
    parameter int unsigned AW = 4,
    parameter int unsigned CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            map_we,
    input  logic [2*AW-1:0] map_addr,
    input  logic            map_wdata,
    input  logic            start,
    input  logic            move_valid,
    input  logic [1:0]      move,
    input  logic            done_in,
    output logic [AW-1:0]   pos_x,
    output logic [AW-1:0]   pos_y,
    output logic [CW-1:0]   step_count,
    output logic            busy,
    output logic            goal,
    output logic            collide,
    output logic            overrun,
    output logic            incomplete
);

    typedef enum logic [1:0] {IDLE, TRACK, GOAL, ERROR} state_t;

    state_t          state, state_nx;
    logic            map_q [2**(2*AW)];
    logic [AW:0]     cand_x, cand_y;
    logic            off_grid, wall_hit, goal_cell;
    logic [AW-1:0]   pos_x_nx, pos_y_nx;
    logic [CW-1:0]   step_nx;
    logic            goal_nx, collide_nx, overrun_nx, incomplete_nx;

    assign busy = (state == TRACK);

    // Wall map is deliberately outside reset so a loaded maze survives rst.
    always_ff @(posedge clk) begin
        if (map_we && !busy)
            map_q[map_addr] <= map_wdata;
    end

    // One extra bit catches wrap below 0 (all ones) and past max (2**AW).
    always_comb begin
        cand_x = {1'b0, pos_x};
        cand_y = {1'b0, pos_y};
        case (move)
            2'b00:   cand_y = cand_y - 1'b1;
            2'b01:   cand_x = cand_x + 1'b1;
            2'b10:   cand_x = cand_x - 1'b1;
            default: cand_y = cand_y + 1'b1;
        endcase
        off_grid  = cand_x[AW] | cand_y[AW];
        wall_hit  = map_q[{cand_y[AW-1:0], cand_x[AW-1:0]}];
        goal_cell = (cand_x[AW-1:0] == '1) && (cand_y[AW-1:0] == '1);
    end

    always_comb begin
        state_nx      = state;
        pos_x_nx      = pos_x;
        pos_y_nx      = pos_y;
        step_nx       = step_count;
        goal_nx       = goal;
        collide_nx    = collide;
        overrun_nx    = overrun;
        incomplete_nx = incomplete;
        if (start) begin
            state_nx      = TRACK;
            pos_x_nx      = '0;
            pos_y_nx      = '0;
            step_nx       = '0;
            goal_nx       = 1'b0;
            collide_nx    = 1'b0;
            overrun_nx    = 1'b0;
            incomplete_nx = 1'b0;
        end else begin
            case (state)
                TRACK: begin
                    if (move_valid) begin
                        if (off_grid || wall_hit) begin
                            state_nx      = ERROR;
                            collide_nx    = 1'b1;
                            incomplete_nx = done_in;
                        end else begin
                            pos_x_nx = cand_x[AW-1:0];
                            pos_y_nx = cand_y[AW-1:0];
                            step_nx  = (step_count == '1) ? step_count : step_count + 1'b1;
                            if (goal_cell) begin
                                state_nx = GOAL;
                                goal_nx  = 1'b1;
                            end else if (done_in) begin
                                state_nx      = ERROR;
                                incomplete_nx = 1'b1;
                            end
                        end
                    end else if (done_in) begin
                        state_nx      = ERROR;
                        incomplete_nx = 1'b1;
                    end
                end
                GOAL: begin
                    if (move_valid) begin
                        state_nx   = ERROR;
                        overrun_nx = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pos_x      <= '0;
            pos_y      <= '0;
            step_count <= '0;
            goal       <= 1'b0;
            collide    <= 1'b0;
            overrun    <= 1'b0;
            incomplete <= 1'b0;
        end else begin
            state      <= state_nx;
            pos_x      <= pos_x_nx;
            pos_y      <= pos_y_nx;
            step_count <= step_nx;
            goal       <= goal_nx;
            collide    <= collide_nx;
            overrun    <= overrun_nx;
            incomplete <= incomplete_nx;
        end
    end

endmodule

// File: tb/tb_maze_move_checker.sv
// Bench for maze_move_checker: directed scenarios with literal expectations plus
// randomized move streams compared every cycle against a coordinate-level model.
module tb_maze_move_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       map_we = 1'b0;
    logic [7:0] map_addr = '0;
    logic       map_wdata = 1'b0;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move = '0;
    logic       done_in = 1'b0;
    logic [3:0] pos_x, pos_y;
    logic [7:0] step_count;
    logic       busy, goal, collide, overrun, incomplete;

    int checks = 0;
    int errors = 0;

    maze_move_checker #(.AW(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .map_we(map_we), .map_addr(map_addr),
        .map_wdata(map_wdata), .start(start), .move_valid(move_valid),
        .move(move), .done_in(done_in), .pos_x(pos_x), .pos_y(pos_y),
        .step_count(step_count), .busy(busy), .goal(goal), .collide(collide),
        .overrun(overrun), .incomplete(incomplete)
    );

    always #5 clk = ~clk;

    // Reference model: a walker on a 16x16 grid with plain integer coordinates.
    bit mmap [256];
    int mx = 0, my = 0, mcnt = 0;
    bit walking = 0, parked = 0;
    bit mgoal = 0, mcol = 0, mover = 0, minc = 0;
    int dx, dy, nx, ny;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx = 0; my = 0; mcnt = 0; walking = 0; parked = 0;
            mgoal = 0; mcol = 0; mover = 0; minc = 0;
        end else begin
            if (map_we && !walking) mmap[map_addr] = map_wdata;
            if (start) begin
                mx = 0; my = 0; mcnt = 0; walking = 1; parked = 0;
                mgoal = 0; mcol = 0; mover = 0; minc = 0;
            end else if (walking) begin
                if (move_valid) begin
                    dx = (move == 2'd1) ? 1 : (move == 2'd2) ? -1 : 0;
                    dy = (move == 2'd0) ? -1 : (move == 2'd3) ? 1 : 0;
                    nx = mx + dx;
                    ny = my + dy;
                    if (nx < 0 || nx > 15 || ny < 0 || ny > 15 || mmap[ny*16 + nx]) begin
                        mcol = 1; walking = 0;
                        if (done_in) minc = 1;
                    end else begin
                        mx = nx; my = ny;
                        if (mcnt < 255) mcnt++;
                        if (nx == 15 && ny == 15) begin
                            mgoal = 1; walking = 0; parked = 1;
                        end else if (done_in) begin
                            minc = 1; walking = 0;
                        end
                    end
                end else if (done_in) begin
                    minc = 1; walking = 0;
                end
            end else if (parked && move_valid) begin
                mover = 1; parked = 0;
            end
        end
    end

    logic [20:0] act_vec, exp_vec;
    always @(negedge clk) begin
        act_vec = {pos_x, pos_y, step_count, busy, goal, collide, overrun, incomplete};
        exp_vec = {4'(mx), 4'(my), 8'(mcnt), walking, mgoal, mcol, mover, minc};
        checks++;
        if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL cycle_compare t=%0t actual=%h required=%h (x,y,cnt,busy,goal,col,ovr,inc)",
                     $time, act_vec, exp_vec);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; returns at negedge+1 after the edge consumed them.
    task automatic step(input bit st, input bit mvv, input logic [1:0] mv, input bit dn,
                        input bit we, input logic [7:0] addr, input bit wd);
        start = st; move_valid = mvv; move = mv; done_in = dn;
        map_we = we; map_addr = addr; map_wdata = wd;
        @(negedge clk); #1;
        start = 0; move_valid = 0; done_in = 0; map_we = 0;
    endtask

    task automatic mv(input logic [1:0] d, input bit dn);
        step(0, 1, d, dn, 0, 8'd0, 0);
    endtask

    task automatic load_map(input int density);
        for (int i = 0; i < 256; i++)
            step(0, 0, 2'd0, 0, 1, 8'(i), (density > 0) && ($urandom_range(0, 99) < density));
    endtask

    task automatic pulse_reset();
        rst = 0;
        @(negedge clk); #1;
        rst = 1;
    endtask

    initial begin
        #1 rst = 0;
        #12 rst = 1;
        @(negedge clk); #1;
        check("reset_busy", busy, 0);
        check("reset_pos", {pos_x, pos_y}, 0);

        // 1: open maze, diagonal-by-edges path to goal
        load_map(0);
        step(1, 0, 2'd0, 0, 0, 8'd0, 0);
        check("s1_busy", busy, 1);
        for (int i = 0; i < 15; i++) mv(2'b01, 0);
        for (int i = 0; i < 15; i++) mv(2'b11, 0);
        check("s1_goal", goal, 1);
        check("s1_pos", {pos_x, pos_y}, 8'hFF);
        check("s1_steps", step_count, 30);
        check("s1_flags", {collide, overrun, incomplete}, 0);
        // 4: move after goal
        mv(2'b01, 0);
        check("s4_overrun", overrun, 1);
        check("s4_goal", goal, 1);
        check("s4_pos", {pos_x, pos_y}, 8'hFF);

        // 2: wall at y=0,x=2
        step(0, 0, 2'd0, 0, 1, 8'd2, 1);
        step(1, 0, 2'd0, 0, 0, 8'd0, 0);
        mv(2'b01, 0);
        mv(2'b01, 0);
        check("s2_collide", collide, 1);
        check("s2_pos", {pos_x, pos_y}, 8'h10);
        check("s2_steps", step_count, 1);
        check("s2_busy", busy, 0);

        // 3: off-grid up from origin
        step(1, 0, 2'd0, 0, 0, 8'd0, 0);
        mv(2'b00, 0);
        check("s3_collide", collide, 1);
        check("s3_pos", {pos_x, pos_y}, 0);

        // 5: done before goal
        step(1, 0, 2'd0, 0, 0, 8'd0, 0);
        mv(2'b11, 0); mv(2'b11, 0); mv(2'b01, 0);
        step(0, 0, 2'd0, 1, 0, 8'd0, 0);
        check("s5_incomplete", incomplete, 1);
        check("s5_steps", step_count, 3);
        check("s5_collide", collide, 0);

        // 6: reset mid-track, and map write during track is dropped
        step(1, 0, 2'd0, 0, 0, 8'd0, 0);
        for (int i = 0; i < 5; i++) mv(2'b11, 0);
        step(0, 0, 2'd0, 0, 1, 8'h51, 1);
        rst = 0;
        #3;
        check("s6_pos", {pos_x, pos_y}, 0);
        check("s6_steps", step_count, 0);
        check("s6_flags", {busy, goal, collide, overrun, incomplete}, 0);
        @(negedge clk); #1;
        rst = 1;
        step(1, 0, 2'd0, 0, 0, 8'd0, 0);
        for (int i = 0; i < 5; i++) mv(2'b11, 0);
        mv(2'b01, 0);
        check("s6_map_kept", collide, 0);
        check("s6_pos2", {pos_x, pos_y}, 8'h15);

        // Randomized episodes biased toward right/down so the goal is reachable.
        for (int ep = 0; ep < 60; ep++) begin
            if (ep % 3 == 0) load_map((ep % 2 == 0) ? 4 : 12);
            step(1, 0, 2'd0, 0, 0, 8'd0, 0);
            for (int k = 0; k < 60; k++) begin
                logic [1:0] d;
                d = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                                : ($urandom_range(0, 1) ? 2'b01 : 2'b11);
                if ($urandom_range(0, 199) == 0) pulse_reset();
                step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, d,
                     $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                     8'($urandom_range(1, 255)), $urandom_range(0, 9) == 0);
            end
        end

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
